// File: rtl/philo_table_pkg.sv
// Shared definitions for the dining-philosophers table: event types,
// philosopher state encodings and small elaboration-time helpers.
package philo_table_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Event type carried in the LSB of each FIFO entry.
    localparam logic PHILO_HUNGRY = 1'b0;
    localparam logic PHILO_DONE   = 1'b1;

    typedef enum logic [1:0] {
        THINKING = 2'd0,
        HUNGRY   = 2'd1,
        EATING   = 2'd2
    } philo_state_e;

    // Ceiling log2, never below 1 so it can size a vector directly.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int s = 0; s < 31; s++) begin
            if ((1 << s) < value) r = s + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/philo_table_fifo.sv
// First-word-fall-through event FIFO. The head entry is visible on rd_data_o
// whenever the FIFO is not empty; rd_data_o reads zero while empty.
module philo_evt_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr     = wr_en_i && !full_o;
    assign do_rd     = rd_en_i && !empty_o;
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance on accepted write / pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset discards all stored entries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/philo_table.sv
// N_PHILO philosopher state machines with private timers. Their HUNGRY/DONE
// events wait in a per-philosopher pending slot until a round-robin arbiter
// moves them, tagged with the philosopher id, into one shared event FIFO.
module philo_table
    import philo_table_pkg::*;
#(
    parameter int  N_PHILO    = 5,
    parameter int  EAT_TIME   = 2,
    parameter int  THINK_TIME = 5,
    parameter int  FIFO_DEPTH = 8,
    localparam int ID_W       = log2(N_PHILO)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_PHILO-1:0] may_eat,
    output logic [N_PHILO-1:0] hungry,
    input  logic               fout_ack,
    output logic [ID_W:0]      fout_data,
    output logic               fout_empty,
    output logic [N_PHILO-1:0] proto_err
);

    localparam int TMR_W = log2(max(EAT_TIME, THINK_TIME) + 1);

    logic [N_PHILO-1:0] pend_vec;
    logic [N_PHILO-1:0] ptype_vec;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_vld;
    logic               fifo_full;

    // Index base+step, wrapped into 0..N_PHILO-1.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int step);
        int s;
        s = int'(base) + step;
        if (s >= N_PHILO) s = s - N_PHILO;
        return s[ID_W-1:0];
    endfunction

    // Grant the first pending philosopher at or after rr_q; full blocks all.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = N_PHILO - 1; k >= 0; k--) begin
            if (pend_vec[wrap_idx(rr_q, k)] && !fifo_full) begin
                gnt_vld = 1'b1;
                gnt_id  = wrap_idx(rr_q, k);
            end
        end
        rr_d = gnt_vld ? wrap_idx(gnt_id, 1) : rr_q;
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rr_q <= '0;
        else          rr_q <= rr_d;
    end

    for (genvar i = 0; i < N_PHILO; i++) begin : g_philo
        philo_state_e     state_q, state_d;
        logic [TMR_W-1:0] timer_q, timer_d;
        logic             pend_q, pend_d;
        logic             ptype_q, ptype_d;
        logic             perr_q, perr_d;
        logic             gnt_me;

        assign gnt_me = gnt_vld && (gnt_id == ID_W'(i));

        // Timer/state step (frozen while an event waits), then grant handling.
        always_comb begin
            state_d = state_q;
            timer_d = timer_q;
            pend_d  = pend_q;
            ptype_d = ptype_q;
            perr_d  = perr_q;
            if (gnt_me) pend_d = 1'b0;
            if (!pend_q) begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    case (state_q)
                        THINKING: begin
                            pend_d  = 1'b1;
                            ptype_d = PHILO_HUNGRY;
                            state_d = HUNGRY;
                        end
                        EATING: begin
                            pend_d  = 1'b1;
                            ptype_d = PHILO_DONE;
                            state_d = THINKING;
                            timer_d = TMR_W'(THINK_TIME);
                        end
                        default: ;
                    endcase
                end
            end
            // A grant applies even with a HUNGRY event still queued here.
            if (may_eat[i]) begin
                if (state_q == HUNGRY) begin
                    state_d = EATING;
                    timer_d = TMR_W'(EAT_TIME);
                end else begin
                    perr_d = 1'b1;
                end
            end
        end

        // Philosopher registers; reset starts a fresh thinking period.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= THINKING;
                timer_q <= TMR_W'(THINK_TIME);
                pend_q  <= 1'b0;
                ptype_q <= PHILO_HUNGRY;
                perr_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
                pend_q  <= pend_d;
                ptype_q <= ptype_d;
                perr_q  <= perr_d;
            end
        end

        assign hungry[i]    = (state_q == HUNGRY);
        assign pend_vec[i]  = pend_q;
        assign ptype_vec[i] = ptype_q;
        assign proto_err[i] = perr_q;
    end

    philo_evt_fifo #(
        .WIDTH (ID_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en_i   (gnt_vld),
        .wr_data_i ({gnt_id, ptype_vec[gnt_id]}),
        .rd_en_i   (fout_ack),
        .rd_data_o (fout_data),
        .full_o    (fifo_full),
        .empty_o   (fout_empty)
    );

endmodule
